pipeline_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RV32 pipeline. Combines four event sources into per-stage register enables and bubble-inserts:
  - load-use stall request from the hazard unit
  - EX-stage branch/jump redirect
  - variable-latency data-memory wait
  - iterative divider busy
- Sits beside the hazard unit; drives every pipeline register's write and flush input.

---
 rtl/pipeline_pkg.sv | 30 +++
 rtl/sat_counter.sv | 34 +++
 rtl/pipeline_ctrl.sv | 148 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32 pipeline stall/flush sequencer.
package pipeline_pkg;

    typedef enum logic [1:0] {
        ST_RUN          = 2'd0,
        ST_MEM_WAIT     = 2'd1,
        ST_DIV_WAIT     = 2'd2,
        ST_MEM_DIV_WAIT = 2'd3
    } state_e;

    localparam int unsigned MEM_TIMEOUT_DEF = 255;
    localparam int unsigned CNT_W_DEF       = 32;

    // Pipeline register indices; PC is treated as stage 0.
    localparam int unsigned STG_PC    = 0;
    localparam int unsigned STG_IFID  = 1;
    localparam int unsigned STG_IDEX  = 2;
    localparam int unsigned STG_EXMEM = 3;
    localparam int unsigned STG_MEMWB = 4;
    localparam int unsigned NUM_STG   = 5;

    function automatic logic in_mem_wait(input state_e s);
        return (s == ST_MEM_WAIT) || (s == ST_MEM_DIV_WAIT);
    endfunction

    function automatic logic in_div_wait(input state_e s);
        return (s == ST_DIV_WAIT) || (s == ST_MEM_DIV_WAIT);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable and synchronous clear that holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: merges load-use, redirect, data-memory wait and
// divider busy into per-stage register enables and bubble inserts.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             LoadUseStall,
    input  logic             BranchTakenE,
    input  logic             DMemReqM,
    input  logic             DMemReadyM,
    input  logic             DivStartE,
    input  logic             DivDoneE,
    output logic             PCWrite,
    output logic             IFID_Write,
    output logic             IDEX_Write,
    output logic             EXMEM_Write,
    output logic             MEMWB_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Flush,
    output logic             EXMEM_Flush,
    output logic             MEMWB_Flush,
    output logic             MemTimeoutErr,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);

    state_e state_q;
    state_e state_d;
    logic   div_done_pend_q;
    logic   div_done_pend_d;
    logic   mem_timeout_err_q;
    logic   mem_timeout_err_d;

    logic   memstall;
    logic   div_active;
    logic   div_done;
    logic   divstall;
    logic   wait_mem;

    logic [NUM_STG-1:0]        wr;
    logic [NUM_STG-1:STG_IFID] fl;
    logic [TO_W-1:0]           tcnt;

    // Event decode; a latched divider result counts as done.
    always_comb begin
        memstall   = DMemReqM & ~DMemReadyM;
        div_active = in_div_wait(state_q) | DivStartE;
        div_done   = DivDoneE | div_done_pend_q;
        divstall   = div_active & ~div_done;
        wait_mem   = in_mem_wait(state_q);
    end

    // Stage enables by priority: memory wait, divider, redirect, load-use.
    always_comb begin
        wr = '1;
        fl = '0;
        if (memstall) begin
            wr[STG_PC]    = 1'b0;
            wr[STG_IFID]  = 1'b0;
            wr[STG_IDEX]  = 1'b0;
            wr[STG_EXMEM] = 1'b0;
            fl[STG_MEMWB] = 1'b1;
        end else if (divstall) begin
            wr[STG_PC]    = 1'b0;
            wr[STG_IFID]  = 1'b0;
            wr[STG_IDEX]  = 1'b0;
            fl[STG_EXMEM] = 1'b1;
        end else if (BranchTakenE) begin
            fl[STG_IFID]  = 1'b1;
            fl[STG_IDEX]  = 1'b1;
        end else if (LoadUseStall) begin
            wr[STG_PC]    = 1'b0;
            wr[STG_IFID]  = 1'b0;
            fl[STG_IDEX]  = 1'b1;
        end
    end

    // Next state tracks which stall sources remain outstanding.
    always_comb begin
        state_d           = state_q;
        div_done_pend_d   = div_done_pend_q;
        mem_timeout_err_d = mem_timeout_err_q;

        unique case ({divstall, memstall})
            2'b00:   state_d = ST_RUN;
            2'b01:   state_d = ST_MEM_WAIT;
            2'b10:   state_d = ST_DIV_WAIT;
            default: state_d = ST_MEM_DIV_WAIT;
        endcase

        // Hold a divider result that lands while EX is frozen by memory.
        div_done_pend_d = memstall & (div_done_pend_q | DivDoneE);

        if (wait_mem && (tcnt == TO_W'(MEM_TIMEOUT - 1))) begin
            mem_timeout_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= ST_RUN;
            div_done_pend_q   <= 1'b0;
            mem_timeout_err_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            div_done_pend_q   <= div_done_pend_d;
            mem_timeout_err_q <= mem_timeout_err_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (1'b0),
        .en_i  (~wr[STG_PC]),
        .cnt_o (StallCycles)
    );

    sat_counter #(
        .W (TO_W)
    ) u_timeout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (~wait_mem),
        .en_i  (wait_mem),
        .cnt_o (tcnt)
    );

    // Reset holds every register closed and loading bubbles.
    assign PCWrite       = rst_n & wr[STG_PC];
    assign IFID_Write    = rst_n & wr[STG_IFID];
    assign IDEX_Write    = rst_n & wr[STG_IDEX];
    assign EXMEM_Write   = rst_n & wr[STG_EXMEM];
    assign MEMWB_Write   = rst_n & wr[STG_MEMWB];
    assign IFID_Flush    = ~rst_n | fl[STG_IFID];
    assign IDEX_Flush    = ~rst_n | fl[STG_IDEX];
    assign EXMEM_Flush   = ~rst_n | fl[STG_EXMEM];
    assign MEMWB_Flush   = ~rst_n | fl[STG_MEMWB];
    assign MemTimeoutErr = mem_timeout_err_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table, corner sequences and random traffic
// against a cycle-level reference model.
module tb_pipeline_ctrl;

    localparam int unsigned TB_TIMEOUT = 8;
    localparam int unsigned TB_CNT_W   = 6;
    localparam int          CNT_MAX    = (1 << TB_CNT_W) - 1;

    // Input bundle order: {LoadUse, Branch, Req, Ready, DivStart, DivDone}
    localparam logic [5:0] LU  = 6'b100000;
    localparam logic [5:0] BR  = 6'b010000;
    localparam logic [5:0] REQ = 6'b001000;
    localparam logic [5:0] RDY = 6'b000100;
    localparam logic [5:0] ST  = 6'b000010;
    localparam logic [5:0] DN  = 6'b000001;

    // Output bundle order: {PC, IFID_W, IDEX_W, EXMEM_W, MEMWB_W, IFID_F, IDEX_F, EXMEM_F, MEMWB_F}
    localparam logic [8:0] O_NORM  = 9'b1_1111_0000;
    localparam logic [8:0] O_RST   = 9'b0_0000_1111;
    localparam logic [8:0] O_MEM   = 9'b0_0001_0001;
    localparam logic [8:0] O_DIV   = 9'b0_0011_0010;
    localparam logic [8:0] O_BR    = 9'b1_1111_1100;
    localparam logic [8:0] O_LU    = 9'b0_0111_0100;

    logic clk;
    logic rst_n;
    logic LoadUseStall, BranchTakenE, DMemReqM, DMemReadyM, DivStartE, DivDoneE;
    logic PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write;
    logic IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush;
    logic MemTimeoutErr;
    logic [TB_CNT_W-1:0] StallCycles;

    pipeline_ctrl #(
        .MEM_TIMEOUT (TB_TIMEOUT),
        .CNT_W       (TB_CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .LoadUseStall  (LoadUseStall),
        .BranchTakenE  (BranchTakenE),
        .DMemReqM      (DMemReqM),
        .DMemReadyM    (DMemReadyM),
        .DivStartE     (DivStartE),
        .DivDoneE      (DivDoneE),
        .PCWrite       (PCWrite),
        .IFID_Write    (IFID_Write),
        .IDEX_Write    (IDEX_Write),
        .EXMEM_Write   (EXMEM_Write),
        .MEMWB_Write   (MEMWB_Write),
        .IFID_Flush    (IFID_Flush),
        .IDEX_Flush    (IDEX_Flush),
        .EXMEM_Flush   (EXMEM_Flush),
        .MEMWB_Flush   (MEMWB_Flush),
        .MemTimeoutErr (MemTimeoutErr),
        .StallCycles   (StallCycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: what stalled last cycle, a latched divide result,
    // consecutive memory-wait cycles, sticky error, stall-cycle tally.
    bit m_prev_mem, m_prev_div, m_pend, m_err;
    int m_tcount, m_stalls;

    logic [8:0]          last_outs;
    logic [TB_CNT_W-1:0] last_stall;
    logic                last_err;

    typedef struct {
        logic [5:0] in;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_prev_mem = 0; m_prev_div = 0; m_pend = 0; m_err = 0;
        m_tcount = 0; m_stalls = 0;
    endtask

    // One clock: drive at negedge, compare before posedge, advance model after it.
    task automatic cycle(input logic r, input logic [5:0] in);
        logic ms, ds, busy;
        logic [8:0] exp;
        @(negedge clk);
        rst_n = r;
        {LoadUseStall, BranchTakenE, DMemReqM, DMemReadyM, DivStartE, DivDoneE} = in;
        #1;
        if (!r) model_reset();
        ms   = in[3] & ~in[2];
        busy = m_prev_div | in[1];
        ds   = busy & ~(in[0] | m_pend);
        if (!r)         exp = O_RST;
        else if (ms)    exp = O_MEM;
        else if (ds)    exp = O_DIV;
        else if (in[4]) exp = O_BR;
        else if (in[5]) exp = O_LU;
        else            exp = O_NORM;
        last_outs  = {PCWrite, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write,
                      IFID_Flush, IDEX_Flush, EXMEM_Flush, MEMWB_Flush};
        last_stall = StallCycles;
        last_err   = MemTimeoutErr;
        chk("outs", 32'(last_outs), 32'(exp));
        chk("stall_cycles", 32'(last_stall), 32'(m_stalls));
        chk("timeout_err", 32'(last_err), 32'(m_err));
        @(posedge clk);
        if (r) begin
            if (m_prev_mem) m_tcount++;
            else            m_tcount = 0;
            if (m_prev_mem && (m_tcount == int'(TB_TIMEOUT))) m_err = 1;
            if (!exp[8] && (m_stalls < CNT_MAX)) m_stalls++;
            m_pend     = ms & (m_pend | in[0]);
            m_prev_mem = ms;
            m_prev_div = ds;
        end
    endtask

    initial begin
        logic [5:0] rin;
        int burst;
        rst_n = 1'b0;
        {LoadUseStall, BranchTakenE, DMemReqM, DMemReadyM, DivStartE, DivDoneE} = '0;
        model_reset();

        vecs[0]  = '{6'b0,               O_NORM};
        vecs[1]  = '{LU,                 O_LU};
        vecs[2]  = '{BR,                 O_BR};
        vecs[3]  = '{BR | LU,            O_BR};
        vecs[4]  = '{REQ,                O_MEM};
        vecs[5]  = '{REQ | RDY,          O_NORM};
        vecs[6]  = '{ST,                 O_DIV};
        vecs[7]  = '{ST | DN,            O_NORM};
        vecs[8]  = '{ST | BR,            O_DIV};
        vecs[9]  = '{ST | DN | BR,       O_BR};
        vecs[10] = '{REQ | ST | BR | LU, O_MEM};
        vecs[11] = '{RDY,                O_NORM};
        vecs[12] = '{DN | LU,            O_LU};
        vecs[13] = '{REQ | RDY | ST | LU, O_DIV};

        // Reset and release
        cycle(1'b0, '0);
        cycle(1'b0, '0);
        chk("reset_outs", 32'(last_outs), 32'(O_RST));
        chk("reset_stall", 32'(last_stall), 32'd0);
        cycle(1'b1, '0);
        chk("idle_outs", 32'(last_outs), 32'(O_NORM));
        chk("idle_stall", 32'(last_stall), 32'd0);

        // Single-cycle priority table from RUN
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, '0);
            cycle(1'b1, vecs[i].in);
            chk($sformatf("vec%0d", i), 32'(last_outs), 32'(vecs[i].exp));
        end

        // Load-use stall
        cycle(1'b0, '0);
        cycle(1'b1, LU);
        chk("lu_outs", 32'(last_outs), 32'(O_LU));
        cycle(1'b1, '0);
        chk("lu_stall", 32'(last_stall), 32'd1);

        // Three-cycle memory wait
        cycle(1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, REQ);
            chk("memwait_outs", 32'(last_outs), 32'(O_MEM));
        end
        cycle(1'b1, REQ | RDY);
        chk("mem_release_outs", 32'(last_outs), 32'(O_NORM));
        cycle(1'b1, '0);
        chk("mem_stall_cnt", 32'(last_stall), 32'd3);

        // Divide with a pending redirect held the whole time
        cycle(1'b0, '0);
        cycle(1'b1, ST | BR);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, BR);
            chk("div_no_redirect", 32'(last_outs), 32'(O_DIV));
        end
        cycle(1'b1, DN | BR);
        chk("div_done_redirect", 32'(last_outs), 32'(O_BR));
        cycle(1'b1, '0);
        chk("div_stall_cnt", 32'(last_stall), 32'd5);

        // Divider finishes inside a memory wait
        cycle(1'b0, '0);
        cycle(1'b1, ST | REQ);
        cycle(1'b1, REQ);
        cycle(1'b1, REQ | DN);
        cycle(1'b1, REQ);
        chk("pend_mem_outs", 32'(last_outs), 32'(O_MEM));
        cycle(1'b1, REQ | RDY);
        chk("pend_release_outs", 32'(last_outs), 32'(O_NORM));
        cycle(1'b1, '0);
        chk("pend_run_outs", 32'(last_outs), 32'(O_NORM));
        chk("pend_stall_cnt", 32'(last_stall), 32'd4);

        // Memory timeout, then reset mid-wait
        cycle(1'b0, '0);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, REQ);
            if (i == 8) chk("timeout_not_yet", 32'(last_err), 32'd0);
        end
        chk("timeout_set", 32'(last_err), 32'd1);
        cycle(1'b1, REQ);
        chk("timeout_sticky", 32'(last_err), 32'd1);
        cycle(1'b0, REQ);
        chk("timeout_reset_err", 32'(last_err), 32'd0);
        chk("timeout_reset_stall", 32'(last_stall), 32'd0);
        cycle(1'b1, '0);
        chk("after_reset_outs", 32'(last_outs), 32'(O_NORM));
        chk("after_reset_err", 32'(last_err), 32'd0);

        // Random traffic with occasional long memory waits and resets
        burst = 0;
        for (int n = 0; n < 3000; n++) begin
            rin[5] = ($urandom_range(0, 99) < 15);
            rin[4] = ($urandom_range(0, 99) < 15);
            rin[3] = ($urandom_range(0, 99) < 35);
            rin[2] = ($urandom_range(0, 99) < 50);
            rin[1] = ($urandom_range(0, 99) < 10);
            rin[0] = ($urandom_range(0, 99) < 15);
            if (burst == 0 && $urandom_range(0, 149) == 0) burst = 12;
            if (burst > 0) begin
                rin[3] = 1'b1;
                rin[2] = 1'b0;
                burst--;
            end
            cycle(($urandom_range(0, 299) != 0), rin);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
